// File: rtl/quiz_sequencer.sv
// Arithmetic-quiz game controller: LFSR operand generation, per-question countdown,
// answer capture/grading and score keeping across a fixed number of rounds.
module quiz_sequencer #(
    parameter int unsigned NUM_QUESTIONS    = 10,
    parameter int unsigned TICKS_PER_SEC    = 100_000_000,
    parameter int unsigned QUESTION_SECONDS = 10,
    parameter int unsigned FEEDBACK_TICKS   = 50_000_000,
    parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       enter_flag_i,
    input  logic [6:0] user_answer_i,
    output logic [6:0] op_a_o,
    output logic [6:0] op_b_o,
    output logic [4:0] question_idx_o,
    output logic [4:0] score_o,
    output logic [3:0] seconds_left_o,
    output logic       kb_clear_o,
    output logic       correct_pulse_o,
    output logic       wrong_pulse_o,
    output logic       timeout_pulse_o,
    output logic       busy_o,
    output logic       game_over_o
);

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SEC_W  = 4;
    localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned FB_W   = (FEEDBACK_TICKS > 1) ? $clog2(FEEDBACK_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ASK,
        S_CHECK,
        S_FEEDBACK,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              start_q, enter_q;
    logic [OP_W-1:0]   ans_hold_q, ans_hold_d;
    logic [OP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [IDX_W-1:0]  idx_q, idx_d, score_q, score_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [FB_W-1:0]   fb_q, fb_d;
    logic              kb_clear_q, kb_clear_d;
    logic              correct_q, correct_d, wrong_q, wrong_d, timeout_q, timeout_d;
    logic              busy_q, busy_d, game_over_q, game_over_d;

    logic              start_rise, enter_rise, tick_wrap, fb_done, last_round;
    logic [OP_W-1:0]   sum;

    // Fold 6 LFSR bits into 0..49 by pulling 50..63 down by 32.
    function automatic logic [OP_W-1:0] op_map(input logic [LFSR_W-1:0] s);
        logic [5:0] v;
        v = s[5:0];
        return (v < 6'd50) ? OP_W'(v) : OP_W'(v - 6'd32);
    endfunction

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running.
    assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign start_rise = start_i & ~start_q;
    assign enter_rise = enter_flag_i & ~enter_q;
    // Keyboard zeroes its value after enter, so freeze the capture while enter is high.
    assign ans_hold_d = enter_flag_i ? ans_hold_q : user_answer_i;
    assign tick_wrap  = (tick_q == TICK_W'(TICKS_PER_SEC - 1));
    assign fb_done    = (fb_q == FB_W'(FEEDBACK_TICKS - 1));
    assign last_round = (idx_q == IDX_W'(NUM_QUESTIONS - 1));
    assign sum        = op_a_q + op_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_rise) state_d = S_LOAD_A;
            S_LOAD_A:   state_d = S_LOAD_B;
            S_LOAD_B:   state_d = S_ASK;
            S_ASK: begin
                if (enter_rise) begin
                    state_d = S_CHECK;
                end else if (tick_wrap && sec_q == SEC_W'(1)) begin
                    state_d = S_FEEDBACK;
                end
            end
            S_CHECK:    state_d = S_FEEDBACK;
            S_FEEDBACK: if (fb_done) state_d = last_round ? S_DONE : S_LOAD_A;
            S_DONE:     if (start_rise) state_d = S_LOAD_A;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        idx_d       = idx_q;
        score_d     = score_q;
        sec_d       = sec_q;
        tick_d      = tick_q;
        fb_d        = '0;
        kb_clear_d  = 1'b0;
        correct_d   = 1'b0;
        wrong_d     = 1'b0;
        timeout_d   = 1'b0;
        busy_d      = busy_q;
        game_over_d = game_over_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    score_d     = '0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    game_over_d = 1'b0;
                end
            end
            S_LOAD_A: op_a_d = op_map(lfsr_q);
            S_LOAD_B: begin
                op_b_d     = op_map(lfsr_q);
                sec_d      = SEC_W'(QUESTION_SECONDS);
                tick_d     = '0;
                kb_clear_d = 1'b1;
            end
            S_ASK: begin
                // A simultaneous enter pre-empts the final-second timeout.
                if (!enter_rise) begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        sec_d  = sec_q - SEC_W'(1);
                        if (sec_q == SEC_W'(1)) begin
                            timeout_d  = 1'b1;
                            kb_clear_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_CHECK: begin
                if (ans_hold_q == sum) begin
                    correct_d = 1'b1;
                    score_d   = score_q + IDX_W'(1);
                end else begin
                    wrong_d = 1'b1;
                end
            end
            S_FEEDBACK: begin
                fb_d = fb_q + FB_W'(1);
                if (fb_done) begin
                    fb_d = '0;
                    if (last_round) begin
                        busy_d      = 1'b0;
                        game_over_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= LFSR_SEED;
            start_q     <= 1'b0;
            enter_q     <= 1'b0;
            ans_hold_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            idx_q       <= '0;
            score_q     <= '0;
            sec_q       <= '0;
            tick_q      <= '0;
            fb_q        <= '0;
            kb_clear_q  <= 1'b0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            start_q     <= start_i;
            enter_q     <= enter_flag_i;
            ans_hold_q  <= ans_hold_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            idx_q       <= idx_d;
            score_q     <= score_d;
            sec_q       <= sec_d;
            tick_q      <= tick_d;
            fb_q        <= fb_d;
            kb_clear_q  <= kb_clear_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign op_a_o          = op_a_q;
    assign op_b_o          = op_b_q;
    assign question_idx_o  = idx_q;
    assign score_o         = score_q;
    assign seconds_left_o  = sec_q;
    assign kb_clear_o      = kb_clear_q;
    assign correct_pulse_o = correct_q;
    assign wrong_pulse_o   = wrong_q;
    assign timeout_pulse_o = timeout_q;
    assign busy_o          = busy_q;
    assign game_over_o     = game_over_q;

endmodule

// File: doc/quiz_sequencer.md
# quiz_sequencer

Game controller for the arithmetic-quiz design. It generates addition questions from an internal LFSR and presents the operands to the display path. It runs a per-question countdown, captures the value the player types through `get_kb_val`, and grades it when `enter_flag_out` rises. It keeps score across `NUM_QUESTIONS` rounds and sits between the keyboard entry block and the display/LED top level.

## Interface
- `NUM_QUESTIONS`, 10: rounds per game; legal range 1–31.
- `TICKS_PER_SEC`, 100_000_000: `clk` cycles per countdown second.
- `QUESTION_SECONDS`, 10: countdown start value; legal range 1–15.
- `FEEDBACK_TICKS`, 50_000_000: cycles spent in FEEDBACK.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; rising edge begins a game.
- `enter_flag`  in  1  level from `get_kb_val` (`enter_flag_out`), synchronous to `clk`.
- `user_answer`  in  7  running typed value from `get_kb_val`.
- `op_a`, `op_b`  out  7 each  current operands, 0–49.
- `question_idx`  out  5  current round, 0-based.
- `score`  out  5  correct answers so far.
- `seconds_left`  out  4  countdown value.
- `kb_clear`  out  1  one-cycle pulse; clears keyboard entry.
- `correct_pulse`, `wrong_pulse`, `timeout_pulse`  out  1 each  one-cycle grading result.
- `busy`  out  1  high from game start until DONE is entered.
- `game_over`  out  1  high in DONE.

## Operation
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It shifts every cycle from reset, independent of the FSM state.
- Operand map: v = `lfsr[5:0]`; operand = v if v<50, else v−32.
- Expected sum = `op_a`+`op_b`, 7 bits, maximum 98. No overflow is possible.
- Answer hold: while `enter_flag`=0, `ans_hold` <= `user_answer` every cycle. While `enter_flag`=1, `ans_hold` is frozen. This matters because `get_kb_val` zeroes its value after enter.
- Enter edge: `enter_rise` = `enter_flag` & ~`enter_q`.
- Start edge: detected the same way as the enter edge.

FSM states and transitions:
- IDLE:
  - outputs 0; `busy`=0.
  - `start` rise -> LOAD_A; `score`<=0; `question_idx`<=0.
- LOAD_A: `op_a` <= map(`lfsr`); -> LOAD_B.
- LOAD_B:
  - `op_b` <= map(`lfsr`); `seconds_left` <= `QUESTION_SECONDS`; tick counter <= 0.
  - `kb_clear` pulses this cycle.
  - -> ASK.
- ASK:
  - Tick counter counts 0..`TICKS_PER_SEC`−1; `seconds_left` decrements on wrap.
  - If `enter_rise` -> CHECK.
  - Else if the wrap occurs with `seconds_left`=1: `seconds_left`<=0; `timeout_pulse`; `kb_clear` -> FEEDBACK.
- CHECK:
  - `ans_hold` == sum: `correct_pulse`; `score`+1.
  - Otherwise: `wrong_pulse`.
  - -> FEEDBACK; feedback counter <= 0.
- FEEDBACK:
  - Wait `FEEDBACK_TICKS` cycles.
  - If `question_idx`=`NUM_QUESTIONS`−1 -> DONE.
  - Else `question_idx`+1 -> LOAD_A.
- DONE:
  - `game_over`=1; `busy`=0; `score`, `op_a`, `op_b` held.
  - `start` rise -> LOAD_A with `score` and `question_idx` cleared.

Boundary rules:
- `enter_rise` outside ASK is ignored; it is not queued.
- `start` rise while `busy` is ignored.
- `enter_rise` and the final-second wrap in the same cycle: enter wins, no timeout.
- An entry of 0 is graded normally. It is correct only if the sum is 0.

## Timing
- All outputs are registered.
- Reset values:
  - State = IDLE; LFSR = `LFSR_SEED`.
  - `op_a`, `op_b`, `question_idx`, `score`, `seconds_left` = 0.
  - All pulse outputs = 0; `busy` = 0; `game_over` = 0.
- Reset is asynchronous and takes effect mid-game with no drain.
- `start` rise at cycle N:
  - `busy`=1 at N+1; LOAD_A at N+1; LOAD_B at N+2.
  - `kb_clear` and `seconds_left`=`QUESTION_SECONDS` visible at N+3.
- `enter_flag` rising at cycle M in ASK:
  - Grade pulse and updated `score` visible at M+2.
- Timeout occurs exactly `QUESTION_SECONDS`×`TICKS_PER_SEC` cycles after ASK entry.

## Test plan
Parameters for every scenario: `TICKS_PER_SEC`=4, `QUESTION_SECONDS`=3, `FEEDBACK_TICKS`=2, `NUM_QUESTIONS`=2.

- Reset check:
  - Stimulus: assert `rst_n`=0 mid-ASK.
  - Response: all outputs return to their reset values asynchronously; state IDLE; next `start` rise begins a fresh game.
- Correct answer:
  - Stimulus: `user_answer`=`op_a`+`op_b`, then `enter_flag` rises.
  - Response: `correct_pulse` 2 cycles later; `score`=1; `kb_clear` at the next LOAD_B.
- Wrong answer plus edge case:
  - Stimulus: `user_answer`=sum+1, enter rises; `user_answer` is forced to 0 in the same cycle enter rises.
  - Response: `wrong_pulse`; `score` unchanged. Hold check: an entry equal to the sum, zeroed as enter rises, is still graded correct.
- Timeout:
  - Stimulus: no enter.
  - Response: `seconds_left` goes 3,2,1,0; `timeout_pulse` and `kb_clear` exactly 12 cycles after ASK entry.
- Collision:
  - Stimulus: enter rises on the final wrap cycle.
  - Response: graded; no `timeout_pulse`.
- Full game:
  - Stimulus: two correct answers.
  - Response: `game_over`=1; `score`=2; `busy`=0; `start` pulses during the game are ignored; `start` in DONE restarts with `score`=0.
  - Operands must match the bench LFSR model on every round.
